// File: rtl/e203_exu_fpu_fmis_wbck_pkg.sv
// rtl/e203_exu_fpu_fmis_wbck_pkg.sv - shared types and widths for the FMIS write-back collector
package e203_exu_fpu_fmis_wbck_pkg;

  localparam int ITAG_W_DEF  = 5;
  localparam int XLEN_DEF    = 32;
  localparam int RFIDX_W_DEF = 5;

  typedef enum logic {
    NORMAL = 1'b0,
    DRAIN  = 1'b1
  } fmis_state_e;

  // Tracker entry layout, MSB to LSB: {itag, rdidx, rdfpu}
  function automatic int trk_ent_w(input int itag_w, input int rfidx_w);
    return itag_w + rfidx_w + 1;
  endfunction

endpackage

// File: rtl/e203_exu_fpu_fmis_trk.sv
// rtl/e203_exu_fpu_fmis_trk.sv - in-order circular tracker FIFO for issued FMIS ops
module e203_exu_fpu_fmis_trk #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned W     = 11
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       clear,
  input  logic [W-1:0]               din,
  output logic [W-1:0]               dout,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] rd_ptr_q, wr_ptr_q;
  logic [PW:0]   cnt_q;
  logic          do_push, do_pop;

  assign full    = (cnt_q == (PW+1)'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem_q[rd_ptr_q];
  assign count   = cnt_q;

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

  // Clear wins over a same-cycle push/pop so a flushed issue never lands
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      cnt_q <= cnt_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/e203_exu_fpu_fmis_wbck.sv
// rtl/e203_exu_fpu_fmis_wbck.sv - FMIS result collector: pairs results with tracked dests, flush drain
module e203_exu_fpu_fmis_wbck
  import e203_exu_fpu_fmis_wbck_pkg::*;
#(
  parameter int unsigned DEPTH   = 2,
  parameter int unsigned ITAG_W  = ITAG_W_DEF,
  parameter int unsigned XLEN    = XLEN_DEF,
  parameter int unsigned RFIDX_W = RFIDX_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               iss_valid,
  input  logic               iss_ready,
  input  logic [ITAG_W-1:0]  iss_itag,
  input  logic [RFIDX_W-1:0] iss_rdidx,
  input  logic               iss_rdfpu,
  output logic               iss_stall,
  input  logic               flush_pulse,
  input  logic               fmis_o_valid,
  output logic               fmis_o_ready,
  input  logic [XLEN-1:0]    fmis_o_wbck_wdat,
  input  logic               fmis_o_wbck_err,
  output logic               wbck_o_valid,
  input  logic               wbck_o_ready,
  output logic [XLEN-1:0]    wbck_o_wdat,
  output logic [RFIDX_W-1:0] wbck_o_rdidx,
  output logic               wbck_o_rdfpu,
  output logic [ITAG_W-1:0]  wbck_o_itag,
  output logic               wbck_o_err,
  output logic               trk_ovf
);

  localparam int ENT_W = trk_ent_w(ITAG_W, RFIDX_W);
  localparam int CW    = $clog2(DEPTH) + 1;

  fmis_state_e        state_q, state_d;
  logic [CW-1:0]      drain_q, drain_d;
  logic               obuf_vld_q, obuf_vld_d;
  logic [XLEN-1:0]    wdat_q, wdat_d;
  logic               err_q, err_d;
  logic [RFIDX_W-1:0] rdidx_q, rdidx_d;
  logic               rdfpu_q, rdfpu_d;
  logic [ITAG_W-1:0]  itag_q, itag_d;
  logic               trk_ovf_q, trk_ovf_d;

  logic               iss_hs, res_hs, push, pop, clear;
  logic [ENT_W-1:0]   trk_dout;
  logic [CW-1:0]      trk_count;
  logic               trk_full, trk_empty;

  assign iss_hs = iss_valid & iss_ready;

  e203_exu_fpu_fmis_trk #(.DEPTH(DEPTH), .W(ENT_W)) u_trk (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .clear (clear),
    .din   ({iss_itag, iss_rdidx, iss_rdfpu}),
    .dout  (trk_dout),
    .count (trk_count),
    .full  (trk_full),
    .empty (trk_empty)
  );

  always_comb begin
    state_d      = state_q;
    drain_d      = drain_q;
    obuf_vld_d   = obuf_vld_q;
    wdat_d       = wdat_q;
    err_d        = err_q;
    rdidx_d      = rdidx_q;
    rdfpu_d      = rdfpu_q;
    itag_d       = itag_q;
    trk_ovf_d    = trk_ovf_q | (iss_hs & trk_full);
    fmis_o_ready = 1'b0;
    res_hs       = 1'b0;
    push         = 1'b0;
    pop          = 1'b0;
    clear        = 1'b0;
    case (state_q)
      NORMAL: begin
        fmis_o_ready = ~trk_empty & (~obuf_vld_q | wbck_o_ready);
        res_hs       = fmis_o_valid & fmis_o_ready;
        push         = iss_hs;
        pop          = res_hs;
        if (flush_pulse) begin
          // Results still owed by FMIS: tracked ops plus this cycle's issue, minus this cycle's return
          clear      = 1'b1;
          obuf_vld_d = 1'b0;
          drain_d    = trk_count + CW'(iss_hs & ~trk_full) - CW'(res_hs);
          if (drain_d != '0) state_d = DRAIN;
        end else begin
          if (wbck_o_ready) obuf_vld_d = 1'b0;
          if (res_hs) begin
            obuf_vld_d = 1'b1;
            wdat_d     = fmis_o_wbck_wdat;
            err_d      = fmis_o_wbck_err;
            {itag_d, rdidx_d, rdfpu_d} = trk_dout;
          end
        end
      end
      DRAIN: begin
        fmis_o_ready = 1'b1;
        res_hs       = fmis_o_valid;
        if (res_hs) begin
          drain_d = drain_q - CW'(1);
          if (drain_q == CW'(1)) state_d = NORMAL;
        end
      end
      default: state_d = NORMAL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= NORMAL;
      drain_q    <= '0;
      obuf_vld_q <= 1'b0;
      wdat_q     <= '0;
      err_q      <= 1'b0;
      rdidx_q    <= '0;
      rdfpu_q    <= 1'b0;
      itag_q     <= '0;
      trk_ovf_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      drain_q    <= drain_d;
      obuf_vld_q <= obuf_vld_d;
      wdat_q     <= wdat_d;
      err_q      <= err_d;
      rdidx_q    <= rdidx_d;
      rdfpu_q    <= rdfpu_d;
      itag_q     <= itag_d;
      trk_ovf_q  <= trk_ovf_d;
    end
  end

  assign iss_stall    = trk_full | (state_q == DRAIN);
  assign wbck_o_valid = obuf_vld_q;
  assign wbck_o_wdat  = wdat_q;
  assign wbck_o_err   = err_q;
  assign wbck_o_rdidx = rdidx_q;
  assign wbck_o_rdfpu = rdfpu_q;
  assign wbck_o_itag  = itag_q;
  assign trk_ovf      = trk_ovf_q;

endmodule

// File: tb/tb_e203_exu_fpu_fmis_wbck.sv
// tb/tb_e203_exu_fpu_fmis_wbck.sv - self-checking bench for the FMIS write-back collector
module tb_e203_exu_fpu_fmis_wbck;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        iss_valid, iss_ready, iss_rdfpu, iss_stall, flush_pulse;
  logic [4:0]  iss_itag, iss_rdidx;
  logic        fmis_o_valid, fmis_o_ready, fmis_o_wbck_err;
  logic [31:0] fmis_o_wbck_wdat;
  logic        wbck_o_valid, wbck_o_ready, wbck_o_rdfpu, wbck_o_err, trk_ovf;
  logic [31:0] wbck_o_wdat;
  logic [4:0]  wbck_o_rdidx, wbck_o_itag;

  int total = 0;
  int bad   = 0;

  e203_exu_fpu_fmis_wbck #(.DEPTH(DEPTH), .ITAG_W(5), .XLEN(32), .RFIDX_W(5)) dut (
    .clk(clk), .rst(rst),
    .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_itag(iss_itag),
    .iss_rdidx(iss_rdidx), .iss_rdfpu(iss_rdfpu), .iss_stall(iss_stall),
    .flush_pulse(flush_pulse),
    .fmis_o_valid(fmis_o_valid), .fmis_o_ready(fmis_o_ready),
    .fmis_o_wbck_wdat(fmis_o_wbck_wdat), .fmis_o_wbck_err(fmis_o_wbck_err),
    .wbck_o_valid(wbck_o_valid), .wbck_o_ready(wbck_o_ready),
    .wbck_o_wdat(wbck_o_wdat), .wbck_o_rdidx(wbck_o_rdidx),
    .wbck_o_rdfpu(wbck_o_rdfpu), .wbck_o_itag(wbck_o_itag),
    .wbck_o_err(wbck_o_err), .trk_ovf(trk_ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] itag;
    logic [4:0] rd;
    logic       fpu;
  } ent_t;

  // Reference model: pending ops in issue order, one output slot, a count of results owed after flush
  ent_t        m_trk[$];
  logic        m_ob_v;
  ent_t        m_ob;
  logic [31:0] m_ob_wd;
  logic        m_ob_er;
  int          m_owed;
  logic        m_ovf;

  function automatic logic m_stall();
    return (m_trk.size() == DEPTH) || (m_owed > 0);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    iss_valid = 0; iss_ready = 0; iss_itag = 0; iss_rdidx = 0; iss_rdfpu = 0;
    flush_pulse = 0; fmis_o_valid = 0; fmis_o_wbck_wdat = 0; fmis_o_wbck_err = 0;
    wbck_o_ready = 0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_wbck_valid", 32'(wbck_o_valid), 0);
    chk("rst_wdat", wbck_o_wdat, 0);
    chk("rst_rdidx_itag", {wbck_o_rdidx, wbck_o_itag, wbck_o_rdfpu, wbck_o_err}, 0);
    chk("rst_fmis_ready", 32'(fmis_o_ready), 0);
    chk("rst_stall", 32'(iss_stall), 0);
    chk("rst_ovf", 32'(trk_ovf), 0);
    m_trk.delete();
    m_ob_v = 0; m_owed = 0; m_ovf = 0;
    rst = 1'b0;
  endtask

  task automatic step(input logic iv, input logic ir, input logic [4:0] it, input logic [4:0] rd,
                      input logic fp, input logic fl, input logic fv, input logic [31:0] wd,
                      input logic er, input logic wr);
    logic exp_rdy, ihs, rhs, was_full;
    int   n;
    @(negedge clk);
    iss_valid = iv; iss_ready = ir; iss_itag = it; iss_rdidx = rd; iss_rdfpu = fp;
    flush_pulse = fl; fmis_o_valid = fv; fmis_o_wbck_wdat = wd; fmis_o_wbck_err = er;
    wbck_o_ready = wr;
    #1;
    exp_rdy = (m_owed > 0) ? 1'b1 : ((m_trk.size() != 0) && (!m_ob_v || wr));
    chk("fmis_o_ready", 32'(fmis_o_ready), 32'(exp_rdy));
    chk("iss_stall", 32'(iss_stall), 32'(m_stall()));
    chk("wbck_o_valid", 32'(wbck_o_valid), 32'(m_ob_v));
    chk("trk_ovf", 32'(trk_ovf), 32'(m_ovf));
    if (m_ob_v) begin
      chk("wbck_wdat", wbck_o_wdat, m_ob_wd);
      chk("wbck_fields", {wbck_o_itag, wbck_o_rdidx, wbck_o_rdfpu, wbck_o_err},
          {m_ob.itag, m_ob.rd, m_ob.fpu, m_ob_er});
    end
    @(posedge clk);
    ihs = iv & ir;
    rhs = fv & exp_rdy;
    was_full = (m_trk.size() == DEPTH);
    if (ihs && was_full) m_ovf = 1;
    if (m_owed > 0) begin
      if (rhs) m_owed--;
    end else if (fl) begin
      n = m_trk.size() + ((ihs && !was_full) ? 1 : 0) - (rhs ? 1 : 0);
      m_trk.delete();
      m_ob_v = 0;
      m_owed = n;
    end else begin
      if (m_ob_v && wr) m_ob_v = 0;
      if (rhs) begin
        m_ob = m_trk.pop_front();
        m_ob_wd = wd; m_ob_er = er; m_ob_v = 1;
      end
      if (ihs && !was_full) m_trk.push_back('{itag: it, rd: rd, fpu: fp});
    end
  endtask

  task automatic idle(input logic wr);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, wr);
  endtask

  initial begin
    do_reset();

    // Single op: result two cycles after issue
    step(1, 1, 5'd3, 5'd5, 1, 0, 0, 0, 0, 1);
    idle(1);
    step(0, 0, 0, 0, 0, 0, 1, 32'h3F800000, 0, 1);
    idle(1);
    idle(1);

    // Back-to-back issue fills the tracker, results in order
    step(1, 1, 5'd7, 5'd1, 0, 0, 0, 0, 0, 1);
    step(1, 1, 5'd8, 5'd2, 1, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 1, 32'h11111111, 0, 1);
    step(0, 0, 0, 0, 0, 0, 1, 32'h22222222, 1, 1);
    idle(1);

    // Backpressure while obuf is occupied
    step(1, 1, 5'd9, 5'd3, 0, 0, 0, 0, 0, 1);
    step(1, 1, 5'd10, 5'd4, 1, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 1, 32'hAAAA0001, 0, 0);
    repeat (3) step(0, 0, 0, 0, 0, 0, 1, 32'hAAAA0002, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1, 32'hAAAA0002, 0, 1);
    idle(1);
    idle(1);

    // Flush with two outstanding, both results swallowed
    step(1, 1, 5'd11, 5'd6, 0, 0, 0, 0, 0, 1);
    step(1, 1, 5'd12, 5'd7, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 1, 32'hDEAD0001, 0, 1);
    step(0, 0, 0, 0, 0, 0, 1, 32'hDEAD0002, 0, 1);
    idle(1);

    // Flush coincident with result and issue at count=1
    step(1, 1, 5'd13, 5'd8, 1, 0, 0, 0, 0, 1);
    step(1, 1, 5'd14, 5'd9, 0, 1, 1, 32'hBEEF0001, 0, 1);
    idle(1);
    step(0, 0, 0, 0, 0, 0, 1, 32'hBEEF0002, 0, 1);
    idle(1);
    idle(1);

    // Random traffic against the reference model
    for (int i = 0; i < 400; i++) begin
      logic iv, fl, fv, wr;
      iv = ($urandom_range(0, 1) == 1) && !m_stall();
      fl = ($urandom_range(0, 19) == 0);
      fv = ($urandom_range(0, 2) != 0);
      wr = ($urandom_range(0, 3) != 0);
      step(iv, $urandom_range(0, 3) != 0, 5'($urandom), 5'($urandom), 1'($urandom),
           fl, fv, $urandom, 1'($urandom), wr);
    end
    // Let any owed results settle before the overflow case
    for (int i = 0; i < 8; i++) step(0, 0, 0, 0, 0, 0, 1, $urandom, 0, 1);

    // Overflow: an issue handshake while full is dropped and sticks
    step(1, 1, 5'd20, 5'd10, 0, 0, 0, 0, 0, 1);
    step(1, 1, 5'd21, 5'd11, 1, 0, 0, 0, 0, 1);
    step(1, 1, 5'd22, 5'd12, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 1, 32'h0000C001, 0, 1);
    step(0, 0, 0, 0, 0, 0, 1, 32'h0000C002, 0, 1);
    step(0, 0, 0, 0, 0, 0, 1, 32'h0000C003, 0, 1);
    idle(1);
    idle(1);
    do_reset();
    idle(1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
